// File: rtl/spi_host_fifo.sv
// rtl/spi_host_fifo.sv - SPI master with TX/RX FIFOs behind a flat register bus
// Optional build macro SPI_LOOPBACK_EN: CTRL[5] routes sd_o back into the receiver.
module spi_host_fifo #(
   parameter int NUM_CS     = 4,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [3:0]        be_i,
   input  logic              we_i,
   input  logic              re_i,
   output logic [31:0]       rdata_o,
   output logic              error_o,
   output logic              intr_o,
   output logic [NUM_CS-1:0] ss_o,
   output logic              sclk_o,
   output logic              sd_o,
   input  logic              sd_i
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LVL_W = PTR_W + 1;
   localparam int H_W   = $clog2(2 * DATA_W);
   localparam logic [H_W-1:0]   H_LAST  = H_W'(2 * DATA_W - 1);
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
   localparam logic [7:0] A_CTRL = 8'h00, A_DIV = 8'h04, A_CS = 8'h08, A_TX = 8'h0C,
                          A_RX = 8'h10, A_STAT = 8'h14, A_INTR = 8'h18;

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
   state_t state, state_d;

   logic              en, cpol, cpha, lsb_first, ie, lb;
   logic [DIV_W-1:0]  div;
   logic [NUM_CS-1:0] cs_mask;
   logic              cs_keep, rx_ovf, done;

   logic              cpol_q, cpha_q, lsb_q;
   logic [DIV_W-1:0]  div_q, cnt;
   logic [H_W-1:0]    h;
   logic [DATA_W-1:0] tx_sh, rx_sh;
   logic              sd_q, sdi;

   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  tx_wp, tx_rp, rx_wp, rx_rp;
   logic [LVL_W-1:0]  tx_lvl, rx_lvl;
   logic              tx_full, tx_empty, rx_full, rx_empty;

   logic mapped, wr_ok, wr_ctrl, en_d;
   logic tx_push, tx_pop, rx_pop, rx_wr;
   logic tick, lead_go, drive, sample, rx_done, set_done;
   logic [31:0] rd;
   logic unused_wdata;

   assign unused_wdata = ^wdata_i;

   function automatic logic obit(input logic [DATA_W-1:0] d, input logic lsb);
      return lsb ? d[0] : d[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic lsb);
      return lsb ? (d >> 1) : (d << 1);
   endfunction

   always_comb begin
      mapped   = (addr_i == A_CTRL) || (addr_i == A_DIV) || (addr_i == A_CS) || (addr_i == A_TX) ||
                 (addr_i == A_RX) || (addr_i == A_STAT) || (addr_i == A_INTR);
      wr_ok    = we_i && (be_i == 4'hF) && mapped;
      wr_ctrl  = wr_ok && (addr_i == A_CTRL);
      tx_full  = (tx_lvl == DEPTH_L);
      tx_empty = (tx_lvl == '0);
      rx_full  = (rx_lvl == DEPTH_L);
      rx_empty = (rx_lvl == '0);
      tx_push  = wr_ok && (addr_i == A_TX) && !tx_full;
      rx_pop   = re_i && (addr_i == A_RX) && !rx_empty;
      error_o  = ((we_i || re_i) && !mapped) || (we_i && (be_i != 4'hF)) ||
                 (wr_ok && (addr_i == A_TX) && tx_full) || (re_i && (addr_i == A_RX) && rx_empty);
      // Clearing en aborts at the very edge that writes it, so the bus sees IDLE next cycle.
      en_d     = wr_ctrl ? wdata_i[0] : en;
      sdi      = lb ? sd_q : sd_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d  = state;
      tx_pop   = 1'b0;
      lead_go  = 1'b0;
      drive    = 1'b0;
      sample   = 1'b0;
      rx_done  = 1'b0;
      set_done = 1'b0;
      tick     = (cnt == div_q);
      case (state)
         IDLE: if (en && !tx_empty) begin
            state_d = LEAD;
            tx_pop  = 1'b1;
            lead_go = 1'b1;
         end
         LEAD: if (!en_d) state_d = IDLE;
         else if (tick) begin
            state_d = SHIFT;
            drive   = cpha_q;
            sample  = !cpha_q;
         end
         SHIFT: if (!en_d) state_d = IDLE;
         else if (tick) begin
            if (h == H_LAST) begin
               state_d = TRAIL;
               rx_done = 1'b1;
            end else if (h[0]) begin
               drive  = cpha_q;
               sample = !cpha_q;
            end else begin
               drive  = !cpha_q;
               sample = cpha_q;
            end
         end
         TRAIL: if (!en_d) state_d = IDLE;
         else if (tick) begin
            if (!tx_empty) begin
               state_d = LEAD;
               tx_pop  = 1'b1;
               lead_go = 1'b1;
            end else begin
               state_d  = IDLE;
               set_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sclk_o = (state == SHIFT) ? (cpol_q ^ ~h[0]) : ((state == IDLE) ? cpol : cpol_q);
   assign ss_o   = ~(cs_mask & {NUM_CS{(state != IDLE) || cs_keep}});
   assign sd_o   = sd_q;
   assign intr_o = done && ie;
   assign rx_wr  = rx_done && (!rx_full || rx_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0; h <= '0; div_q <= '0;
         cpol_q <= 1'b0; cpha_q <= 1'b0; lsb_q <= 1'b0;
         tx_sh <= '0; rx_sh <= '0; sd_q <= 1'b0;
      end else begin
         if ((state == IDLE) || (state_d != state) || tick) cnt <= '0;
         else cnt <= cnt + DIV_W'(1);
         if (state != SHIFT) h <= '0;
         else if (tick) h <= h + H_W'(1);
         // Frame format is frozen at LEAD so mid-burst register writes apply to the next frame.
         if (lead_go) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            div_q  <= div;
            rx_sh  <= '0;
            if (cpha) tx_sh <= tx_mem[tx_rp];
            else begin
               tx_sh <= shift_out(tx_mem[tx_rp], lsb_first);
               sd_q  <= obit(tx_mem[tx_rp], lsb_first);
            end
         end
         if (drive) begin
            sd_q  <= obit(tx_sh, lsb_q);
            tx_sh <= shift_out(tx_sh, lsb_q);
         end
         if (sample) rx_sh <= lsb_q ? {sdi, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], sdi};
      end
   end

   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wp] <= wdata_i[DATA_W-1:0];
      if (rx_wr)   rx_mem[rx_wp] <= rx_sh;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_wp <= '0; tx_rp <= '0; tx_lvl <= '0;
         rx_wp <= '0; rx_rp <= '0; rx_lvl <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + PTR_W'(1);
         if (tx_pop)  tx_rp <= tx_rp + PTR_W'(1);
         if (tx_push && !tx_pop)      tx_lvl <= tx_lvl + LVL_W'(1);
         else if (!tx_push && tx_pop) tx_lvl <= tx_lvl - LVL_W'(1);
         if (rx_wr)  rx_wp <= rx_wp + PTR_W'(1);
         if (rx_pop) rx_rp <= rx_rp + PTR_W'(1);
         if (rx_wr && !rx_pop)      rx_lvl <= rx_lvl + LVL_W'(1);
         else if (!rx_wr && rx_pop) rx_lvl <= rx_lvl - LVL_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         en <= 1'b0; cpol <= 1'b0; cpha <= 1'b0; lsb_first <= 1'b0; ie <= 1'b0;
         div <= '0; cs_mask <= '0; cs_keep <= 1'b0; rx_ovf <= 1'b0; done <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en        <= wdata_i[0];
            cpol      <= wdata_i[1];
            cpha      <= wdata_i[2];
            lsb_first <= wdata_i[3];
            ie        <= wdata_i[4];
         end
         if (wr_ok && (addr_i == A_DIV)) div <= wdata_i[DIV_W-1:0];
         if (wr_ok && (addr_i == A_CS)) begin
            cs_mask <= wdata_i[NUM_CS-1:0];
            cs_keep <= wdata_i[31];
         end
         if (rx_done && rx_full && !rx_pop)                       rx_ovf <= 1'b1;
         else if (wr_ok && (addr_i == A_STAT) && wdata_i[5])      rx_ovf <= 1'b0;
         if (set_done)                                            done <= 1'b1;
         else if (wr_ok && (addr_i == A_INTR) && wdata_i[0])      done <= 1'b0;
      end
   end

`ifdef SPI_LOOPBACK_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        lb <= 1'b0;
      else if (wr_ctrl) lb <= wdata_i[5];
   end
`else
   assign lb = 1'b0;
`endif

   always_comb begin
      rd = '0;
      case (addr_i)
         A_CTRL: rd[5:0] = {lb, ie, lsb_first, cpha, cpol, en};
         A_DIV:  rd[DIV_W-1:0] = div;
         A_CS: begin
            rd[NUM_CS-1:0] = cs_mask;
            rd[31]         = cs_keep;
         end
         A_RX:   if (!rx_empty) rd[DATA_W-1:0] = rx_mem[rx_rp];
         A_STAT: begin
            rd[5:0]   = {rx_ovf, rx_empty, rx_full, tx_empty, tx_full, state != IDLE};
            rd[15:8]  = 8'(tx_lvl);
            rd[23:16] = 8'(rx_lvl);
         end
         A_INTR: rd[0] = done;
         default: rd = '0;
      endcase
      rdata_o = re_i ? rd : 32'h0;
   end
endmodule

// File: tb/tb_spi_host_fifo.sv
// tb/tb_spi_host_fifo.sv - directed self-checking bench for spi_host_fifo with an RX scoreboard
module tb_spi_host_fifo;
   localparam int NUM_CS = 4, DATA_W = 8, FIFO_DEPTH = 8, DIV_W = 16;

   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] addr = 8'h0;
   logic [31:0] wdata = 32'h0;
   logic [3:0] be = 4'h0;
   logic we = 1'b0, re = 1'b0;
   logic [31:0] rdata;
   logic error, intr, sclk, sd_o;
   logic [NUM_CS-1:0] ss;
   logic sd_fix = 1'b1, mirror = 1'b0;
   wire  sd_i = mirror ? sd_o : sd_fix;

   always #5 clk = ~clk;

   spi_host_fifo #(.NUM_CS(NUM_CS), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata), .be_i(be), .we_i(we), .re_i(re),
      .rdata_o(rdata), .error_o(error), .intr_o(intr), .ss_o(ss), .sclk_o(sclk), .sd_o(sd_o), .sd_i(sd_i));

   int n_checks = 0, n_fails = 0;
   logic [DATA_W-1:0] exp_q[$];

   logic mon_clr = 1'b1;
   int ss_low, gaps, edges, low_run;
   logic seen_low, sclk_prev;
   int low_runs[$];
   logic cap[$];

   // Line monitor: CS low time, CS gaps within a burst, SCLK edges, low-phase lengths, MOSI at rising SCLK.
   always @(negedge clk) begin
      if (mon_clr) begin
         ss_low = 0; gaps = 0; edges = 0; low_run = 0; seen_low = 1'b0; sclk_prev = sclk;
         low_runs.delete(); cap.delete();
      end else begin
         if (!ss[0]) begin ss_low++; seen_low = 1'b1; end
         else if (seen_low && !intr) gaps++;
         if (sclk !== sclk_prev) begin
            if (!ss[0]) edges++;
            if (sclk) cap.push_back(sd_o);
            if (sclk && low_run > 0) low_runs.push_back(low_run);
         end
         if (!sclk) low_run++;
         else low_run = 0;
         sclk_prev = sclk;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b, output logic err);
      @(negedge clk);
      addr = a; wdata = d; be = b; we = 1'b1;
      #1 err = error;
      @(posedge clk);
      #1 we = 1'b0; be = 4'h0;
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
      @(negedge clk);
      addr = a; re = 1'b1;
      #1 d = rdata; err = error;
      @(posedge clk);
      #1 re = 1'b0;
   endtask

   task automatic mon_reset();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   task automatic wait_intr(input string tag, input int budget);
      int n = 0;
      while (intr !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      chk(tag, intr, 1);
   endtask

   task automatic wait_edges(input string tag, input int cnt, input int budget);
      int n = 0;
      while (edges < cnt && n < budget) begin @(negedge clk); n++; end
      chk(tag, (edges >= cnt), 1);
   endtask

   task automatic rx_check(input string tag);
      logic [31:0] d;
      logic e;
      logic [DATA_W-1:0] x;
      bus_rd(8'h10, d, e);
      x = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk(tag, d, {24'h0, x});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic e;
      logic [7:0] w, w2;
      int v, bad;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ss", ss, 32'hF);
      chk("rst_sclk", sclk, 0);
      chk("rst_sd", sd_o, 0);
      chk("rst_intr", intr, 0);
      bus_rd(8'h14, d, e); chk("rst_status", d, 32'h14);
      bus_rd(8'h00, d, e); chk("rst_ctrl", d, 0);

      bus_wr(8'h1C, 32'h1, 4'hF, e); chk("unmapped_err", e, 1);
      bus_wr(8'h00, 32'h10, 4'h7, e); chk("partial_be_err", e, 1);
      bus_rd(8'h00, d, e); chk("partial_be_ignored", d, 0);
      bus_rd(8'h0C, d, e); chk("txdata_reads_zero", d, 0);

      // Mode 0, DIV=0, sd_i held high
      bus_wr(8'h04, 32'h0, 4'hF, e);
      bus_wr(8'h08, 32'h1, 4'hF, e);
      bus_wr(8'h00, 32'h10, 4'hF, e);
      bus_wr(8'h0C, 32'hA5, 4'hF, e); chk("m0_push_err", e, 0);
      exp_q.push_back(8'hFF);
      mon_reset();
      bus_wr(8'h00, 32'h11, 4'hF, e);
      wait_intr("m0_done_timeout", 200);
      chk("m0_ss_low_cycles", ss_low, 18);
      chk("m0_bit_count", cap.size(), 8);
      v = 0;
      foreach (cap[i]) v = (v << 1) | int'(cap[i]);
      chk("m0_mosi_bits", v, 32'hA5);
      bus_rd(8'h18, d, e); chk("m0_done", d, 1);
      rx_check("m0_rxdata");
      bus_wr(8'h18, 32'h1, 4'hF, e);
      #1 chk("m0_intr_cleared", intr, 0);

      // Mode 3, LSB first, DIV=3, MISO mirrors MOSI
      bus_wr(8'h00, 32'h1E, 4'hF, e);
      bus_wr(8'h04, 32'h3, 4'hF, e);
      mirror = 1'b1;
      mon_reset();
      bus_wr(8'h0C, 32'h3C, 4'hF, e);
      exp_q.push_back(8'h3C);
      bus_wr(8'h00, 32'h1F, 4'hF, e);
      wait_intr("m3_done_timeout", 400);
      chk("m3_bit_count", cap.size(), 8);
      chk("m3_first_bit", (cap.size() > 0) ? cap[0] : 1'b1, 0);
      v = 0;
      foreach (cap[i]) v = v | (int'(cap[i]) << i);
      chk("m3_mosi_value", v, 32'h3C);
      bad = 0;
      foreach (low_runs[i]) if (low_runs[i] != 4) bad++;
      chk("m3_low_phases", low_runs.size(), 8);
      chk("m3_phase_len4", bad, 0);
      chk("m3_ss_low_cycles", ss_low, 72);
      rx_check("m3_rxdata");
      bus_wr(8'h18, 32'h1, 4'hF, e);
      bus_wr(8'h00, 32'h10, 4'hF, e);
      bus_wr(8'h04, 32'h0, 4'hF, e);

      // TX fill past depth while disabled, then one back-to-back burst
      for (int i = 0; i < 9; i++) begin
         w = 8'($urandom_range(0, 255));
         bus_wr(8'h0C, {24'h0, w}, 4'hF, e);
         if (i < 8) begin
            chk("fill_push_ok", e, 0);
            exp_q.push_back(w);
         end else chk("fill_push_full_err", e, 1);
      end
      bus_rd(8'h14, d, e);
      chk("fill_tx_level", d[15:8], 8);
      chk("fill_tx_full", d[1], 1);
      mon_reset();
      bus_wr(8'h00, 32'h11, 4'hF, e);
      wait_intr("burst_done_timeout", 600);
      chk("burst_ss_low_cycles", ss_low, 144);
      chk("burst_cs_gaps", gaps, 0);
      chk("burst_bits", cap.size(), 64);
      for (int i = 0; i < 8; i++) rx_check("burst_rxdata");
      bus_rd(8'h10, d, e);
      chk("rx_empty_pop_err", e, 1);
      chk("rx_empty_pop_data", d, 0);
      bus_wr(8'h18, 32'h1, 4'hF, e);

      // Nine frames into an 8-deep RX FIFO
      bus_wr(8'h00, 32'h10, 4'hF, e);
      for (int i = 0; i < 8; i++) begin
         w = 8'($urandom_range(0, 255));
         bus_wr(8'h0C, {24'h0, w}, 4'hF, e);
         exp_q.push_back(w);
      end
      bus_wr(8'h00, 32'h11, 4'hF, e);
      repeat (5) @(negedge clk);
      bus_wr(8'h0C, 32'h5A, 4'hF, e); chk("ovf_ninth_push", e, 0);
      wait_intr("ovf_done_timeout", 600);
      bus_rd(8'h14, d, e);
      chk("ovf_flag", d[5], 1);
      chk("ovf_rx_level", d[23:16], 8);
      chk("ovf_rx_full", d[3], 1);
      bus_wr(8'h14, 32'h20, 4'hF, e);
      bus_rd(8'h14, d, e);
      chk("ovf_cleared", d[5], 0);
      chk("ovf_level_kept", d[23:16], 8);
      for (int i = 0; i < 8; i++) rx_check("ovf_rxdata");
      bus_rd(8'h10, d, e); chk("ovf_empty_pop_err", e, 1);
      bus_wr(8'h18, 32'h1, 4'hF, e);

      // Abort by clearing en after three SCLK edges
      bus_wr(8'h00, 32'h10, 4'hF, e);
      bus_wr(8'h04, 32'h3, 4'hF, e);
      w  = 8'($urandom_range(0, 255));
      w2 = 8'($urandom_range(0, 255));
      bus_wr(8'h0C, {24'h0, w}, 4'hF, e);
      bus_wr(8'h0C, {24'h0, w2}, 4'hF, e);
      mon_reset();
      bus_wr(8'h00, 32'h11, 4'hF, e);
      wait_edges("abort_edges_timeout", 3, 500);
      bus_wr(8'h00, 32'h10, 4'hF, e);
      chk("abort_ss_high", ss, 32'hF);
      chk("abort_sclk_cpol", sclk, 0);
      bus_rd(8'h14, d, e);
      chk("abort_tx_level", d[15:8], 1);
      chk("abort_rx_level", d[23:16], 0);
      chk("abort_busy", d[0], 0);
      bus_rd(8'h18, d, e); chk("abort_no_done", d, 0);
      chk("abort_intr", intr, 0);
      exp_q.push_back(w2);
      bus_wr(8'h00, 32'h11, 4'hF, e);
      wait_intr("resume_done_timeout", 400);
      rx_check("resume_rxdata");

      // Asynchronous reset in the middle of a cpol=1 frame, with intr_o high
      bus_wr(8'h00, 32'h12, 4'hF, e);
      bus_wr(8'h0C, 32'hC3, 4'hF, e);
      mon_reset();
      bus_wr(8'h00, 32'h13, 4'hF, e);
      wait_edges("rst_mid_edges_timeout", 5, 500);
      chk("rst_mid_intr_before", intr, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_ss", ss, 32'hF);
      chk("rst_mid_sclk", sclk, 0);
      chk("rst_mid_intr", intr, 0);
      chk("rst_mid_sd", sd_o, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      bus_rd(8'h14, d, e); chk("rst_mid_status", d, 32'h14);
      bus_rd(8'h00, d, e); chk("rst_mid_ctrl", d, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/spi_host_fifo.md
Name: spi_host_fifo

Overview:
Parametrised SPI master, the next generation of the register-bus SPI host. It sits behind the TL-UL register adapter on the same flat register bus (addr/wdata/be/we/re/rdata/error). It adds TX/RX FIFOs, configurable frame width and chip-select count, all four CPOL/CPHA modes, LSB/MSB-first ordering and a programmable SCLK divider. It raises one level interrupt when a queued transfer burst completes.

Parameters:
NUM_CS, 4, number of active-low slave selects (1..8)
DATA_W, 8, bits per SPI frame (4..32)
FIFO_DEPTH, 8, entries per TX and RX FIFO; power of 2, 2..64
DIV_W, 16, width of the SCLK divider register

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
addr_i  input  8  register byte address
wdata_i  input  32  write data
be_i  input  4  byte enables; registers written only when be_i is all ones, otherwise the write is ignored with error_o=1
we_i  input  1  write strobe, one cycle
re_i  input  1  read strobe, one cycle
rdata_o  output  32  read data, combinational on addr_i while re_i=1, else 0
error_o  output  1  combinational; set with an unmapped access, TX push when full, RX pop when empty
intr_o  output  1  level interrupt = INTR_STATE.done & CTRL.ie
ss_o  output  NUM_CS  active-low slave selects
sclk_o  output  1  serial clock
sd_o  output  1  MOSI
sd_i  input  1  MISO

Behaviour:
- Interface: one clock (clk_i). Reset rst_i is asynchronous and active-high.
- Reset values: ss_o all ones, sclk_o 0, sd_o 0, intr_o 0, FIFOs empty, FSM IDLE, all registers 0.
- Register map:
  - 0x00 CTRL: [0] en, [1] cpol, [2] cpha, [3] lsb_first, [4] ie.
  - 0x04 DIV: [DIV_W-1:0]. SCLK half-period is DIV+1 clk cycles.
  - 0x08 CS: [NUM_CS-1:0] select mask, [31] keep (hold CS asserted while idle).
  - 0x0C TXDATA: write-only; pushes wdata[DATA_W-1:0]. Reads return 0.
  - 0x10 RXDATA: read pops the FIFO head and returns it zero-extended.
  - 0x14 STATUS: [0] busy, [1] tx_full, [2] tx_empty, [3] rx_full, [4] rx_empty, [5] rx_ovf (sticky, write 1 clears), [15:8] tx_level, [23:16] rx_level.
  - 0x18 INTR_STATE: [0] done, write 1 clears.
- Chip select: ss_o[i] = ~(CS.mask[i] & (state!=IDLE | CS.keep)).
- sclk_o equals cpol in IDLE/LEAD/TRAIL and toggles in SHIFT.
- FSM:
  - IDLE -> LEAD when en=1 and TX non-empty. On entry to LEAD the TX head is popped into the shift register, and for cpha=0 the first bit is driven on sd_o.
  - LEAD holds DIV+1 cycles, then -> SHIFT.
  - SHIFT makes 2*DATA_W half-periods of DIV+1 cycles each. With cpha=0, sample sd_i on the leading edge and shift out on the trailing edge. With cpha=1, shift out on the leading edge and sample on the trailing edge.
  - Bit order is MSB-first unless lsb_first=1.
  - SHIFT -> TRAIL after the last edge. The received frame is pushed to RX at that transition.
  - TRAIL holds DIV+1 cycles, then -> LEAD if en=1 and TX non-empty (CS stays asserted). Otherwise -> IDLE, setting INTR_STATE.done.
- Frame cost: (2*DATA_W+2)*(DIV+1) cycles.
- Register writes to CTRL.cpol/cpha/lsb_first/DIV while busy take effect from the next LEAD.
- en cleared mid-frame: FSM returns to IDLE on the next cycle and sclk_o returns to cpol. The partial RX frame is discarded, TX contents are kept and done is not set.
- TX push when full (judged pre-edge): data dropped, error_o=1, even if a pop occurs the same cycle.
- RX frame completion while full: frame dropped and rx_ovf set, unless an RXDATA read pops in the same cycle. In that case both proceed and there is no overflow.
- RX pop when empty: rdata_o=0, error_o=1, level unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Levels range 0..FIFO_DEPTH.
- Reset mid-operation: every output returns immediately (asynchronously) to its reset value.

Optional Feature:
SPI_LOOPBACK_EN. When defined, CTRL[5] is a loopback bit: with it set, the receiver samples sd_o internally in place of sd_i, and sd_i is ignored. When undefined, CTRL[5] is not stored, reads 0, and sd_i is always used.

Test Plan:
- Mode 0, DIV=0, DATA_W=8, mask=0x1: push 0xA5 with sd_i tied 1 -> sd_o shows 1,0,1,0,0,1,0,1; ss_o[0] is low for 18 cycles; RXDATA=0xFF; done=1; intr_o=1 when ie=1.
- Mode 3 with lsb_first=1, DIV=3: push 0x3C with loopback (or sd_i mirrored externally) -> first bit on sd_o is 0, each SCLK high/low phase is 4 cycles, RXDATA=0x3C.
- Push 9 words with FIFO_DEPTH=8 and en=0 -> 9th write gives error_o=1 and tx_level=8. Enable -> 8 back-to-back frames with CS held low throughout, then done.
- Run 9 frames without reading RX -> rx_ovf=1 and rx_level=8. Write 0x20 to STATUS -> rx_ovf cleared. Reading RX while empty -> error_o=1.
- Clear en mid-frame after 3 SCLK edges -> ss_o all ones on the next cycle, sclk_o=cpol, remaining TX entries intact, done stays 0.
- Assert rst_i mid-SHIFT -> ss_o=all ones, sclk_o=0 and intr_o=0 in the same cycle; STATUS reads 0x0000_0014 after release.
